// File: rtl/sub_cmp_serial_if.sv
// rtl/sub_cmp_serial_if.sv - operand/result handshake bundle for sub_cmp_serial (SUB_CMP_STICKY_OVF_EN adds sticky overflow)
interface sub_cmp_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;
  logic             lt;
  logic             eq;
  logic             gt;
`ifdef SUB_CMP_STICKY_OVF_EN
  logic             ovf_clr;
  logic             ovf_sticky;

  modport master (
    output in_valid, a, b, bin, signed_mode, out_ready, ovf_clr,
    input  in_ready, out_valid, diff, bout, overflow, lt, eq, gt, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, bin, signed_mode, out_ready, ovf_clr,
    output in_ready, out_valid, diff, bout, overflow, lt, eq, gt, ovf_sticky
  );
`else
  modport master (
    output in_valid, a, b, bin, signed_mode, out_ready,
    input  in_ready, out_valid, diff, bout, overflow, lt, eq, gt
  );

  modport slave (
    input  in_valid, a, b, bin, signed_mode, out_ready,
    output in_ready, out_valid, diff, bout, overflow, lt, eq, gt
  );
`endif
endinterface

// File: rtl/sub_cmp_serial.sv
// rtl/sub_cmp_serial.sv - digit-serial subtractor/comparator (optional SUB_CMP_STICKY_OVF_EN sticky overflow)
module sub_cmp_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sub_cmp_serial_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("sub_cmp_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic             brw_q, sm_q;
  logic [CW-1:0]    cnt_q;
  logic             bout_q, ovf_q, lt_q, eq_q, gt_q;

  logic [DIGIT-1:0] dig;
  logic             brw_msb, brw_out;
  logic [WIDTH-1:0] res_next;
  logic             last, v_flag, lt_flag, eq_flag, accept;

  // Ripple the stored borrow through DIGIT full-subtract slices on the low digit.
  always_comb begin
    logic br;
    br      = brw_q;
    dig     = '0;
    brw_msb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      brw_msb = br;
      dig[i]  = a_q[i] ^ b_q[i] ^ br;
      br      = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br);
    end
    brw_out = br;
  end

  // New digits enter at the top so the final digit leaves the full result aligned.
  assign res_next = (res_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
  assign last     = (cnt_q == CW'(N - 1));
  assign v_flag   = brw_msb ^ brw_out;
  assign lt_flag  = sm_q ? (res_next[WIDTH-1] ^ v_flag) : brw_out;
  assign eq_flag  = (res_next == '0) & (sm_q ? ~v_flag : ~brw_out);
  assign accept   = (state_q == IDLE) & bus.in_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; operands are ignored outside IDLE.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-digit shifting, and result/flag latch on the final digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      diff_q <= '0;
      brw_q  <= 1'b0;
      sm_q   <= 1'b0;
      cnt_q  <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      sm_q  <= bus.signed_mode;
      brw_q <= bus.bin;
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      res_q <= res_next;
      brw_q <= brw_out;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        diff_q <= res_next;
        bout_q <= brw_out;
        ovf_q  <= sm_q & v_flag;
        lt_q   <= lt_flag;
        eq_q   <= eq_flag;
        gt_q   <= ~lt_flag & ~eq_flag;
      end
    end
  end

  assign bus.diff     = diff_q;
  assign bus.bout     = bout_q;
  assign bus.overflow = ovf_q;
  assign bus.lt       = lt_q;
  assign bus.eq       = eq_q;
  assign bus.gt       = gt_q;

`ifdef SUB_CMP_STICKY_OVF_EN
  logic ovf_sticky_q;
  logic ovf_set;

  assign ovf_set = (state_q == BUSY) & last & sm_q & v_flag;

  // Sticky overflow: a set on DONE entry wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky_q <= 1'b0;
    else        ovf_sticky_q <= (ovf_sticky_q & ~bus.ovf_clr) | ovf_set;
  end

  assign bus.ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_sub_cmp_serial.sv
// tb/tb_sub_cmp_serial.sv - self-checking bench for sub_cmp_serial with arithmetic reference model
module tb_sub_cmp_serial;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int NLAT = W / D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  sub_cmp_serial_if #(.WIDTH(W)) bus ();

  sub_cmp_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer arithmetic, flags from the sign of the true result.
  function automatic logic [W+4:0] model(logic [W-1:0] a, logic [W-1:0] b,
                                         logic bin, logic sm);
    longint ua, ub, sa, sb, ru, rs, r;
    logic [W-1:0] d;
    logic bo, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (64'sd1 <<< W) : ua;
    sb = b[W-1] ? ub - (64'sd1 <<< W) : ub;
    ru = ua - ub - longint'(bin);
    rs = sa - sb - longint'(bin);
    d  = ru[W-1:0];
    bo = (ru < 0);
    ov = sm && ((rs < -(64'sd1 <<< (W-1))) || (rs > (64'sd1 <<< (W-1)) - 1));
    r  = sm ? rs : ru;
    return {d, bo, ov, (r < 0), (r == 0), (r > 0)};
  endfunction

  function automatic logic [W+4:0] observed();
    return {bus.diff, bus.bout, bus.overflow, bus.lt, bus.eq, bus.gt};
  endfunction

  // Present operands, wait for acceptance, then count cycles until out_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input logic sm, output int lat);
    int g;
    bus.a = a; bus.b = b; bus.bin = bin; bus.signed_mode = sm;
    bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 20) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_handshake got=%b want=10", {bus.in_ready, bus.out_valid});
    end
    n_tests++;
    if (observed() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", observed());
    end
`ifdef SUB_CMP_STICKY_OVF_EN
    n_tests++;
    if (bus.ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sticky got=%b want=0", bus.ovf_sticky);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF};
    logic [W-1:0] tb_ [6] = '{16'h0234, 16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic         tbin [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         tsm  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [W+4:0] texp [6] = '{{16'h1000, 5'b00001}, {16'h0000, 5'b10100},
                               {16'h7FFF, 5'b01100}, {16'h7FFF, 5'b00001},
                               {16'h0000, 5'b10010}, {16'h8000, 5'b11001}};
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb_[i], tbin[i], tsm[i], lat);
      n_tests++;
      if (lat !== NLAT) begin
        n_fail++;
        $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, NLAT);
      end
      n_tests++;
      if (observed() !== texp[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d] got=%h want=%h", i, observed(), texp[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [W+4:0] want;
    want = {16'h0000, 5'b00010};
    bus.a = 16'hABCD; bus.b = 16'hABCD; bus.bin = 1'b0; bus.signed_mode = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'h1111; bus.b = 16'h0001;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      n_tests++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_busy_ready got=%b want=0", bus.in_ready);
      end
      @(posedge clk); #1; lat++;
    end
    n_tests++;
    if (lat !== NLAT) begin
      n_fail++;
      $display("FAIL hold_latency got=%0d want=%0d", lat, NLAT);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({bus.out_valid, bus.in_ready, observed()} !== {2'b10, want}) begin
        n_fail++;
        $display("FAIL hold_done[%0d] got=%h want=%h", k,
                 {bus.out_valid, bus.in_ready, observed()}, {2'b10, want});
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    finish_op();
    repeat (2) begin
      n_tests++;
      if ({bus.out_valid, bus.in_ready, observed()} !== {2'b01, want}) begin
        n_fail++;
        $display("FAIL hold_after got=%h want=%h",
                 {bus.out_valid, bus.in_ready, observed()}, {2'b01, want});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int t_acc [4];
    int lat;
    logic [W-1:0] a, b;
    logic bin, sm;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom); sm = 1'($urandom);
      bus.a = a; bus.b = b; bus.bin = bin; bus.signed_mode = sm;
      bus.in_valid = 1'b1;
      lat = 0;
      while (!bus.in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
      @(posedge clk); #1;
      t_acc[k] = cyc;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_tests++;
      if (observed() !== model(a, b, bin, sm)) begin
        n_fail++;
        $display("FAIL b2b_result[%0d] got=%h want=%h", k, observed(), model(a, b, bin, sm));
      end
      if (k > 0) begin
        n_tests++;
        if (t_acc[k] - t_acc[k-1] !== NLAT + 2) begin
          n_fail++;
          $display("FAIL b2b_period[%0d] got=%0d want=%0d", k, t_acc[k] - t_acc[k-1], NLAT + 2);
        end
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int lat;
    bit seen;
    do_op(16'h1234, 16'h0234, 1'b0, 1'b0, lat);
    finish_op();
    bus.a = 16'h4321; bus.b = 16'h0001; bus.bin = 1'b0; bus.signed_mode = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.in_ready, bus.out_valid, observed()} !== {2'b10, 21'd0}) begin
      n_fail++;
      $display("FAIL midreset_async got=%h want=%h",
               {bus.in_ready, bus.out_valid, observed()}, {2'b10, 21'd0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_partial got=%b want=0", seen);
    end
    do_op(16'h0005, 16'h0003, 1'b0, 1'b0, lat);
    n_tests++;
    if ({lat[3:0], observed()} !== {4'(NLAT), 16'h0002, 5'b00001}) begin
      n_fail++;
      $display("FAIL midreset_next got=%h want=%h",
               {lat[3:0], observed()}, {4'(NLAT), 16'h0002, 5'b00001});
    end
    finish_op();
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b;
    logic bin, sm;
    for (int k = 0; k < 40; k++) begin
      a = W'($urandom); bin = 1'($urandom); sm = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a - W'(bin);
        default: b = W'($urandom);
      endcase
      do_op(a, b, bin, sm, lat);
      n_tests++;
      if (lat !== NLAT || observed() !== model(a, b, bin, sm)) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h bin=%b sm=%b got lat=%0d res=%h want lat=%0d res=%h",
                 k, a, b, bin, sm, lat, observed(), NLAT, model(a, b, bin, sm));
      end
      finish_op();
    end
  endtask

`ifdef SUB_CMP_STICKY_OVF_EN
  task automatic test_sticky();
    int lat;
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, lat);
    n_tests++;
    if ({bus.overflow, bus.ovf_sticky} !== 2'b11) begin
      n_fail++;
      $display("FAIL sticky_set got=%b want=11", {bus.overflow, bus.ovf_sticky});
    end
    finish_op();
    do_op(16'h0001, 16'h0001, 1'b0, 1'b1, lat);
    n_tests++;
    if ({bus.overflow, bus.ovf_sticky} !== 2'b01) begin
      n_fail++;
      $display("FAIL sticky_hold got=%b want=01", {bus.overflow, bus.ovf_sticky});
    end
    finish_op();
    bus.ovf_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovf_clr = 1'b0;
    n_tests++;
    if (bus.ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear got=%b want=0", bus.ovf_sticky);
    end
    bus.ovf_clr = 1'b1;
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    n_tests++;
    if (bus.ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins got=%b want=1", bus.ovf_sticky);
    end
    finish_op();
    n_tests++;
    if (bus.ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear_after got=%b want=0", bus.ovf_sticky);
    end
    bus.ovf_clr = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.bin         = 1'b0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;
`ifdef SUB_CMP_STICKY_OVF_EN
    bus.ovf_clr     = 1'b0;
`endif
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef SUB_CMP_STICKY_OVF_EN
    test_sticky();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
